dct_block_fetch: RTL

Avalon-MM read master that sits directly upstream of the 64000×32 on-chip pixel memory and turns it into a pixel stream for the DCT engine. On `start` it reads one 8×8 block of 8-bit luma pixels from memory. The pixels are packed 4 per 32-bit word, so each row is 2 words, each block is 16 words, and rows are `stride_words` apart. It emits the 64 pixels, row-major, as an Avalon-ST stream with sop/eop and full backpressure support.

---
 rtl/dct_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/dct_block_fetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// dct_pkg: constants and types shared by the DCT front-end blocks.
//   - block geometry: 8x8 pixels, 8-bit luma, 4 pixels per 32-bit word
//   - fetch FSM state encoding
//   - Avalon-ST pixel stream field widths
package dct_pkg;

  localparam int BLOCK_DIM       = 8;
  localparam int PIX_W           = 8;
  localparam int WORDS_PER_ROW   = 2;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int PIX_PER_WORD    = 4;
  localparam int WORD_W          = PIX_W * PIX_PER_WORD;

  // Avalon-ST pixel stream field widths
  localparam int PIX_CNT_W  = $clog2(BLOCK_DIM * BLOCK_DIM);  // pixel index in block
  localparam int BYTE_SEL_W = $clog2(PIX_PER_WORD);           // pixel index in word
  localparam int WORD_CNT_W = $clog2(WORDS_PER_BLOCK);        // word index in block

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: small first-word-fall-through FIFO.
//   clk, reset : clock and synchronous active-high reset
//   push/wdata : write a word (ignored when full unless popping)
//   pop        : remove the head word
//   rdata      : head word, valid whenever empty is low
//   empty      : no words stored
//   count      : number of words stored (0..DEPTH)
// Simultaneous push and pop always leaves count unchanged, full or empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & (~empty | push);
  assign count   = count_reg;

  // Head is read combinationally so the word is visible the cycle after it is written.
  assign rdata = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset so it can map onto LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/dct_block_fetch.sv
// dct_block_fetch: reads one 8x8 block of packed 8-bit pixels from on-chip
// memory (Avalon-MM, fixed 1-cycle read latency) and streams it row-major
// as Avalon-ST pixels with sop/eop and backpressure.
//   clk, reset          : clock and synchronous active-high reset
//   start               : block request, sampled only while idle
//   base_addr           : word address of the block's top-left word
//   stride_words        : word distance between rows
//   busy, done          : block in progress / one-cycle completion pulse
//   mem_*               : Avalon-MM read master towards the pixel memory
//   pix_*               : Avalon-ST pixel stream towards the DCT engine
module dct_block_fetch
  import dct_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride_words,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [WORD_W-1:0] mem_readdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sop,
  output logic              pix_eop
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t            state_reg, state_next;
  logic [ADDR_W-1:0]       row_addr_reg;
  logic [ADDR_W-1:0]       stride_reg;
  logic [WORD_CNT_W-1:0]   rd_cnt_reg;
  logic                    inflight_reg;
  logic                    done_reg;
  logic [BYTE_SEL_W-1:0]   byte_sel_reg;
  logic [PIX_CNT_W-1:0]    pix_cnt_reg;

  logic [WORD_W-1:0]       fifo_rdata;
  logic                    fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_pop;
  logic [CNT_W:0]          credit_used;
  logic                    credit_ok;
  logic                    issue;
  logic                    last_read;
  logic                    xfer;
  logic                    eop_xfer;

  // A word is owed either in the FIFO or on the read bus; never exceed the FIFO.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};
  assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_DEPTH);
  assign issue       = (state_reg == ST_FETCH) && credit_ok;
  assign last_read   = (rd_cnt_reg == WORD_CNT_W'(WORDS_PER_BLOCK - 1));
  assign xfer        = pix_valid & pix_ready;
  assign eop_xfer    = xfer & (pix_cnt_reg == '1);
  assign fifo_pop    = xfer & (byte_sel_reg == '1);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start)              state_next = ST_FETCH;
      ST_FETCH: if (issue && last_read) state_next = ST_DRAIN;
      ST_DRAIN: if (eop_xfer)           state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy           = (state_reg != ST_IDLE);
    mem_chipselect = issue;
    // Row base plus word-in-row; the bus is driven to zero when not reading.
    mem_address    = issue ? (row_addr_reg + ADDR_W'(rd_cnt_reg[0])) : '0;
  end

  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign done           = done_reg;

  // ---------------- address generation and counters ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      row_addr_reg <= '0;
      stride_reg   <= '0;
      rd_cnt_reg   <= '0;
      inflight_reg <= 1'b0;
      done_reg     <= 1'b0;
      byte_sel_reg <= '0;
      pix_cnt_reg  <= '0;
    end else begin
      inflight_reg <= issue;
      done_reg     <= (state_reg == ST_DRAIN) && eop_xfer;
      if (state_reg == ST_IDLE && start) begin
        row_addr_reg <= base_addr;
        stride_reg   <= stride_words;
        rd_cnt_reg   <= '0;
      end else if (issue) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
        // Second word of a row issued: step to the next row by addition.
        if (rd_cnt_reg[0]) row_addr_reg <= row_addr_reg + stride_reg;
      end
      if (xfer) begin
        byte_sel_reg <= byte_sel_reg + 1'b1;
        pix_cnt_reg  <= pix_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------- read-data buffer ----------------
  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_reg),
    .wdata (mem_readdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- unpacker ----------------
  assign pix_valid = ~fifo_empty;
  // Gated so the unreset FIFO storage never shows through while idle.
  assign pix_data  = pix_valid ? fifo_rdata[byte_sel_reg*PIX_W +: PIX_W] : '0;
  assign pix_sop   = pix_valid & (pix_cnt_reg == '0);
  assign pix_eop   = pix_valid & (pix_cnt_reg == '1);

endmodule
